frame_buf_sched: RTL and testbench
==================================

// Module: frame_buf_sched
// PURPOSE
//  Ping-pong frame-buffer scheduler after the CameraLink AXIS-to-local-stream converter.
//  Allocates one of two frame buffers on frame_start, counts beats into it, aborts on
//  converter errors, and hands completed frames to the downstream reader in completion order.
//  Drives the buffer writer (start/abort/select) and the reader request/ack/done handshake.
// PARAMETERS
//  BEATS_PER_FRAME  524288  64-bit beats per full frame (2048*2048 px / 8)
//  CNT_W            20      beat counter width, must hold BEATS_PER_FRAME-1
// PORTS
//  clk                 in   1      system clock
//  rst                 in   1      synchronous reset, active-high
//  frame_start_i       in   1      1-cycle frame start pulse from converter
//  frame_type_i        in   2      frame type, valid with frame_start_i
//  din_vld             in   1      data beat valid from converter (dout_vld)
//  unexpected_data_i   in   1      converter error: beat beyond frame end
//  unexpected_tlast_i  in   1      converter error: tlast missing at frame end
//  wr_start            out  1      1-cycle pulse: writer begins filling wr_buf_sel
//  wr_abort            out  1      1-cycle pulse: writer discards current fill
//  wr_buf_sel          out  1      buffer index being filled
//  wr_en               out  1      beat accepted into current buffer (din_vld qualified)
//  rd_req              out  1      a READY frame is offered to the reader
//  rd_buf_sel          out  1      buffer offered/being read
//  rd_frame_type       out  2      frame type of offered buffer
//  rd_ack              in   1      reader accepts offer (sampled while rd_req=1)
//  rd_done             in   1      1-cycle pulse: reader finished, release buffer
//  drop_cnt            out  16     frames dropped, no FREE buffer (saturating)
//  err_cnt             out  16     frames aborted on error (saturating)
// BEHAVIOUR
//  - All outputs registered. Reset: all buffers FREE, writer W_IDLE, reader R_IDLE,
//    every output 0, counters 0. Reset mid-frame discards all buffer state.
//  - Per-buffer state: FREE, FILLING, READY, READING; plus per-buffer 2-bit type.
//  - Writer FSM W_IDLE/W_FILL/W_DROP. On frame_start_i in W_IDLE or W_DROP:
//    if any buffer FREE -> pick it (both FREE: pick index != last filled), mark FILLING,
//    latch type, wr_start=1 and wr_buf_sel valid the next cycle, beat cnt=0, go W_FILL;
//    else drop_cnt++, go W_DROP.
//  - W_FILL: each din_vld -> wr_en=1 next cycle, cnt++. Beat with cnt==BEATS_PER_FRAME-1
//    -> buffer READY, W_IDLE. din_vld in the frame_start_i cycle is not counted.
//  - W_FILL abort: unexpected_data_i or unexpected_tlast_i, or frame_start_i before
//    frame complete -> wr_abort pulse, buffer FREE, err_cnt++, go W_DROP (new frame
//    on premature start is dropped, not counted in drop_cnt). Error and final beat in
//    same cycle -> abort wins. Errors outside W_FILL are ignored.
//  - W_DROP: din_vld ignored (wr_en=0) until next frame_start_i.
//  - Reader FSM R_IDLE/R_REQ/R_BUSY. R_IDLE with any READY buffer -> R_REQ: rd_req=1,
//    rd_buf_sel/rd_frame_type = oldest READY (completion order tracked by 1 order bit),
//    held stable until ack. rd_ack & rd_req -> buffer READING, rd_req=0 next cycle,
//    R_BUSY. rd_ack without rd_req ignored.
//  - R_BUSY: rd_done -> buffer FREE next cycle, R_IDLE; rd_done elsewhere ignored.
//  - Buffer freed by rd_done is not allocatable in that same cycle: frame_start_i
//    coincident with the only release -> drop.
//  - Buffer in READY/READING is never reallocated; FILLING never offered to reader.
//  - drop_cnt/err_cnt saturate at 16'hFFFF.
// TESTING (BEATS_PER_FRAME=8)
//  1 start(type=2)+8 beats -> wr_start,sel=0; 8 wr_en; rd_req sel=0 type=2; ack,done -> FREE
//  2 two full frames, no ack -> sel 0 then 1; 3rd start -> drop_cnt=1, no wr_start, no wr_en
//  3 start, 4 beats, unexpected_tlast_i -> wr_abort, err_cnt=1, buffer FREE, no rd_req
//  4 start, 5 beats, new frame_start_i -> wr_abort, err_cnt=1, later beats ignored
//  5 both READY (0 then 1): first rd_req sel=0; after ack+done second rd_req sel=1
//  6 rd_done same cycle as start with both busy -> drop_cnt++; rst mid-fill -> all 0

Source files
------------

// File: rtl/frame_buf_sched.sv
// Ping-pong frame-buffer scheduler: allocates one of two buffers per frame, counts beats,
// aborts on converter errors and offers completed frames to the reader oldest-first.
module frame_buf_sched #(
  parameter int BEATS_PER_FRAME = 524288,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start_i,
  input  logic [1:0]  frame_type_i,
  input  logic        din_vld,
  input  logic        unexpected_data_i,
  input  logic        unexpected_tlast_i,
  output logic        wr_start,
  output logic        wr_abort,
  output logic        wr_buf_sel,
  output logic        wr_en,
  output logic        rd_req,
  output logic        rd_buf_sel,
  output logic [1:0]  rd_frame_type,
  input  logic        rd_ack,
  input  logic        rd_done,
  output logic [15:0] drop_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_READY, B_READING} buf_st_e;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_st_e;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_BUSY} rd_st_e;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_FRAME - 1);

  buf_st_e          buf_st_q   [2];
  buf_st_e          buf_st_d   [2];
  logic [1:0]       buf_type_q [2];
  logic [1:0]       buf_type_d [2];
  wr_st_e           wr_st_q, wr_st_d;
  rd_st_e           rd_st_q, rd_st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             order_q, order_d;
  logic             wr_start_q, wr_start_d;
  logic             wr_abort_q, wr_abort_d;
  logic             wr_buf_sel_q, wr_buf_sel_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_req_q, rd_req_d;
  logic             rd_buf_sel_q, rd_buf_sel_d;
  logic [1:0]       rd_frame_type_q, rd_frame_type_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic free0_s, free1_s, rdy0_s, rdy1_s, alloc_idx_s, offer_idx_s;

  // Next-state logic for buffers, writer, reader and counters.
  always_comb begin
    buf_st_d        = buf_st_q;
    buf_type_d      = buf_type_q;
    wr_st_d         = wr_st_q;
    rd_st_d         = rd_st_q;
    cnt_d           = cnt_q;
    last_d          = last_q;
    order_d         = order_q;
    wr_start_d      = 1'b0;
    wr_abort_d      = 1'b0;
    wr_en_d         = 1'b0;
    wr_buf_sel_d    = wr_buf_sel_q;
    rd_req_d        = rd_req_q;
    rd_buf_sel_d    = rd_buf_sel_q;
    rd_frame_type_d = rd_frame_type_q;
    drop_cnt_d      = drop_cnt_q;
    err_cnt_d       = err_cnt_q;

    free0_s     = (buf_st_q[0] == B_FREE);
    free1_s     = (buf_st_q[1] == B_FREE);
    rdy0_s      = (buf_st_q[0] == B_READY);
    rdy1_s      = (buf_st_q[1] == B_READY);
    alloc_idx_s = (free0_s && free1_s) ? ~last_q : ~free0_s;
    offer_idx_s = (rdy0_s && rdy1_s) ? order_q : rdy1_s;

    // Reader first, so the writer's order update sees a READY buffer that is being taken.
    case (rd_st_q)
      R_IDLE: begin
        if (rdy0_s || rdy1_s) begin
          rd_req_d        = 1'b1;
          rd_buf_sel_d    = offer_idx_s;
          rd_frame_type_d = buf_type_q[offer_idx_s];
          rd_st_d         = R_REQ;
        end else begin
          rd_st_d = R_IDLE;
        end
      end
      R_REQ: begin
        if (rd_ack) begin
          buf_st_d[rd_buf_sel_q] = B_READING;
          rd_req_d               = 1'b0;
          rd_st_d                = R_BUSY;
        end else begin
          rd_st_d = R_REQ;
        end
      end
      R_BUSY: begin
        if (rd_done) begin
          buf_st_d[rd_buf_sel_q] = B_FREE;
          rd_st_d                = R_IDLE;
        end else begin
          rd_st_d = R_BUSY;
        end
      end
      default: rd_st_d = R_IDLE;
    endcase

    case (wr_st_q)
      W_FILL: begin
        if (unexpected_data_i || unexpected_tlast_i || frame_start_i) begin
          wr_abort_d             = 1'b1;
          buf_st_d[wr_buf_sel_q] = B_FREE;
          err_cnt_d              = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
          wr_st_d                = W_DROP;
        end else if (din_vld) begin
          wr_en_d = 1'b1;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == LAST_BEAT) begin
            buf_st_d[wr_buf_sel_q] = B_READY;
            wr_st_d                = W_IDLE;
            // Order bit names the oldest READY buffer when both are READY.
            if (buf_st_d[~wr_buf_sel_q] != B_READY) begin
              order_d = wr_buf_sel_q;
            end else begin
              order_d = order_q;
            end
          end else begin
            wr_st_d = W_FILL;
          end
        end else begin
          wr_st_d = W_FILL;
        end
      end
      W_IDLE, W_DROP: begin
        if (frame_start_i) begin
          if (free0_s || free1_s) begin
            buf_st_d[alloc_idx_s]   = B_FILLING;
            buf_type_d[alloc_idx_s] = frame_type_i;
            last_d                  = alloc_idx_s;
            wr_buf_sel_d            = alloc_idx_s;
            wr_start_d              = 1'b1;
            cnt_d                   = {CNT_W{1'b0}};
            wr_st_d                 = W_FILL;
          end else begin
            drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
            wr_st_d    = W_DROP;
          end
        end else begin
          wr_st_d = wr_st_q;
        end
      end
      default: wr_st_d = W_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_st_q        <= '{B_FREE, B_FREE};
      buf_type_q      <= '{2'b00, 2'b00};
      wr_st_q         <= W_IDLE;
      rd_st_q         <= R_IDLE;
      cnt_q           <= {CNT_W{1'b0}};
      last_q          <= 1'b1;
      order_q         <= 1'b0;
      wr_start_q      <= 1'b0;
      wr_abort_q      <= 1'b0;
      wr_buf_sel_q    <= 1'b0;
      wr_en_q         <= 1'b0;
      rd_req_q        <= 1'b0;
      rd_buf_sel_q    <= 1'b0;
      rd_frame_type_q <= 2'b00;
      drop_cnt_q      <= 16'd0;
      err_cnt_q       <= 16'd0;
    end else begin
      buf_st_q        <= buf_st_d;
      buf_type_q      <= buf_type_d;
      wr_st_q         <= wr_st_d;
      rd_st_q         <= rd_st_d;
      cnt_q           <= cnt_d;
      last_q          <= last_d;
      order_q         <= order_d;
      wr_start_q      <= wr_start_d;
      wr_abort_q      <= wr_abort_d;
      wr_buf_sel_q    <= wr_buf_sel_d;
      wr_en_q         <= wr_en_d;
      rd_req_q        <= rd_req_d;
      rd_buf_sel_q    <= rd_buf_sel_d;
      rd_frame_type_q <= rd_frame_type_d;
      drop_cnt_q      <= drop_cnt_d;
      err_cnt_q       <= err_cnt_d;
    end
  end

  assign wr_start      = wr_start_q;
  assign wr_abort      = wr_abort_q;
  assign wr_buf_sel    = wr_buf_sel_q;
  assign wr_en         = wr_en_q;
  assign rd_req        = rd_req_q;
  assign rd_buf_sel    = rd_buf_sel_q;
  assign rd_frame_type = rd_frame_type_q;
  assign drop_cnt      = drop_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Bench for frame_buf_sched: directed scenarios plus random traffic, every output compared
// each cycle against a queue-based reference model of the buffer scheduler.
module tb_frame_buf_sched;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst, frame_start_i, din_vld, unexpected_data_i, unexpected_tlast_i;
  logic [1:0]  frame_type_i;
  logic        rd_ack, rd_done;
  logic        wr_start, wr_abort, wr_buf_sel, wr_en, rd_req, rd_buf_sel;
  logic [1:0]  rd_frame_type;
  logic [15:0] drop_cnt, err_cnt;

  int checks = 0;
  int errors = 0;

  frame_buf_sched #(.BEATS_PER_FRAME(N), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .frame_start_i(frame_start_i), .frame_type_i(frame_type_i),
    .din_vld(din_vld), .unexpected_data_i(unexpected_data_i),
    .unexpected_tlast_i(unexpected_tlast_i), .wr_start(wr_start), .wr_abort(wr_abort),
    .wr_buf_sel(wr_buf_sel), .wr_en(wr_en), .rd_req(rd_req), .rd_buf_sel(rd_buf_sel),
    .rd_frame_type(rd_frame_type), .rd_ack(rd_ack), .rd_done(rd_done),
    .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: buffer states 0 free, 1 filling, 2 ready, 3 reading; ready queue in completion order.
  int m_st[2];
  int m_ty[2];
  int m_rdyq[$];
  int m_wmode;  // 0 idle, 1 filling, 2 dropping
  int m_rmode;  // 0 idle, 1 offering, 2 busy
  int m_wbuf, m_rbuf, m_cnt, m_last;
  int e_wr_start, e_wr_abort, e_wr_sel, e_wr_en, e_rd_req, e_rd_sel, e_rd_type, e_drop, e_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = '{0, 0};
    m_ty = '{0, 0};
    m_rdyq.delete();
    m_wmode = 0; m_rmode = 0; m_wbuf = 0; m_rbuf = 0; m_cnt = 0; m_last = 1;
    e_wr_start = 0; e_wr_abort = 0; e_wr_sel = 0; e_wr_en = 0;
    e_rd_req = 0; e_rd_sel = 0; e_rd_type = 0; e_drop = 0; e_err = 0;
  endtask

  task automatic model_step();
    int release_buf;
    release_buf = -1;
    e_wr_start = 0; e_wr_abort = 0; e_wr_en = 0;
    if (m_rmode == 0 && m_rdyq.size() > 0) begin
      m_rbuf = m_rdyq[0];
      e_rd_req = 1; e_rd_sel = m_rbuf; e_rd_type = m_ty[m_rbuf]; m_rmode = 1;
    end else if (m_rmode == 1 && rd_ack) begin
      m_st[m_rbuf] = 3; void'(m_rdyq.pop_front()); e_rd_req = 0; m_rmode = 2;
    end else if (m_rmode == 2 && rd_done) begin
      release_buf = m_rbuf; m_rmode = 0;
    end
    if (m_wmode == 1) begin
      if (unexpected_data_i || unexpected_tlast_i || frame_start_i) begin
        e_wr_abort = 1; m_st[m_wbuf] = 0; m_wmode = 2;
        if (e_err < 65535) e_err++;
      end else if (din_vld) begin
        e_wr_en = 1; m_cnt++;
        if (m_cnt == N) begin
          m_st[m_wbuf] = 2; m_rdyq.push_back(m_wbuf); m_wmode = 0;
        end
      end
    end else if (frame_start_i) begin
      if (m_st[0] == 0 || m_st[1] == 0) begin
        if (m_st[0] == 0 && m_st[1] == 0) m_wbuf = 1 - m_last;
        else m_wbuf = (m_st[0] == 0) ? 0 : 1;
        m_st[m_wbuf] = 1; m_ty[m_wbuf] = int'(frame_type_i); m_last = m_wbuf;
        e_wr_start = 1; e_wr_sel = m_wbuf; m_cnt = 0; m_wmode = 1;
      end else begin
        if (e_drop < 65535) e_drop++;
        m_wmode = 2;
      end
    end
    if (release_buf >= 0) m_st[release_buf] = 0;
  endtask

  task automatic compare_all();
    check("wr_start", 32'(wr_start), 32'(e_wr_start));
    check("wr_abort", 32'(wr_abort), 32'(e_wr_abort));
    check("wr_buf_sel", 32'(wr_buf_sel), 32'(e_wr_sel));
    check("wr_en", 32'(wr_en), 32'(e_wr_en));
    check("rd_req", 32'(rd_req), 32'(e_rd_req));
    check("rd_buf_sel", 32'(rd_buf_sel), 32'(e_rd_sel));
    check("rd_frame_type", 32'(rd_frame_type), 32'(e_rd_type));
    check("drop_cnt", 32'(drop_cnt), 32'(e_drop));
    check("err_cnt", 32'(err_cnt), 32'(e_err));
  endtask

  task automatic cyc(input logic r, input logic fs, input logic [1:0] ft, input logic dv,
                     input logic ud, input logic ut, input logic ack, input logic done);
    @(negedge clk);
    rst = r; frame_start_i = fs; frame_type_i = ft; din_vld = dv;
    unexpected_data_i = ud; unexpected_tlast_i = ut; rd_ack = ack; rd_done = done;
    if (r) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic start(input logic [1:0] t);
    cyc(1'b0, 1'b1, t, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic beats(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic ack1();
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic done1();
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    model_reset();
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_rd_req", 32'(rd_req), 32'd0);

    // Single full frame of type 2 through to release.
    start(2'd2); beats(N); idle(2);
    check("t1_offer_sel", 32'(rd_buf_sel), 32'd0);
    check("t1_offer_type", 32'(rd_frame_type), 32'd2);
    ack1(); idle(1); done1(); idle(2);

    // Two frames held, third is dropped; then drained in completion order.
    start(2'd1); beats(N); start(2'd3); beats(N); idle(2);
    start(2'd0); beats(3);
    check("t2_drop", 32'(drop_cnt), 32'd1);
    ack1(); idle(1); done1(); idle(2); ack1(); idle(1); done1(); idle(2);

    // Missing tlast aborts; premature frame start aborts.
    start(2'd0); beats(4);
    cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    beats(3); idle(3);
    check("t3_err", 32'(err_cnt), 32'd1);
    start(2'd1); beats(5); start(2'd2); beats(4); idle(2);
    check("t4_err", 32'(err_cnt), 32'd2);

    // Release coincident with frame start while both buffers are busy -> drop.
    start(2'd1); beats(N); start(2'd2); beats(N); idle(2); ack1(); idle(1);
    cyc(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("t6_drop", 32'(drop_cnt), 32'd2);
    ack1(); idle(1); done1(); idle(2);

    // Reset in the middle of a fill.
    start(2'd3); beats(3);
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);

    // Random traffic.
    for (int i = 0; i < 5000; i++) begin
      cyc(($urandom_range(0, 999) == 0),
          ($urandom_range(0, 19) == 0),
          2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 79) == 0),
          ($urandom_range(0, 79) == 0),
          ($urandom_range(0, 1) == 0),
          ($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
